// File: rtl/mmio_timer_port.sv
// mmio_timer_port: 8-byte memory-mapped window holding a prescaled 8-bit timer/compare
// unit with a sticky match flag, a gated interrupt and an 8-bit output port.
module mmio_timer_port #(
   parameter logic [7:0] BASE_ADDR = 8'hF8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] Address_Data_Bus,
   input  logic [7:0] DataOut_Bus,
   input  logic       RW,
   output logic [7:0] DataIn_Bus,
   output logic       Sel_Hit,
   output logic [7:0] Port_Out,
   output logic       Timer_Irq
);

   localparam logic [2:0] OFF_CTRL  = 3'd0;
   localparam logic [2:0] OFF_PRESC = 3'd1;
   localparam logic [2:0] OFF_CMP   = 3'd2;
   localparam logic [2:0] OFF_CNT   = 3'd3;
   localparam logic [2:0] OFF_STAT  = 3'd4;
   localparam logic [2:0] OFF_PORT  = 3'd5;

   logic       en;
   logic       auto_reload;
   logic       irq_en;
   logic       match;
   logic [7:0] presc;
   logic [7:0] cmp;
   logic [7:0] cnt;
   logic [7:0] port;
   logic [7:0] pcnt;

   logic [2:0] offset;
   logic       wr;
   logic       tick;
   logic       hit;

   assign Sel_Hit   = (Address_Data_Bus[7:3] == BASE_ADDR[7:3]);
   assign offset    = Address_Data_Bus[2:0];
   assign wr        = Sel_Hit && RW;
   assign tick      = en && (pcnt == presc);
   assign hit       = tick && (cnt == cmp);
   assign Port_Out  = port;
   assign Timer_Irq = match & irq_en;

   // Statement order sets priority: W1C clear, then timer events, then bus writes,
   // so a match set beats a clear while CTRL/CNT writes beat the timer.
   always_ff @(posedge clk) begin
      if (!reset) begin
         en          <= 1'b0;
         auto_reload <= 1'b0;
         irq_en      <= 1'b0;
         match       <= 1'b0;
         presc       <= 8'h00;
         cmp         <= 8'h00;
         cnt         <= 8'h00;
         port        <= 8'h00;
         pcnt        <= 8'h00;
      end else begin
         if (en)
            pcnt <= tick ? 8'h00 : pcnt + 8'h01;
         if (wr && (offset == OFF_STAT) && DataOut_Bus[0])
            match <= 1'b0;
         if (tick) begin
            if (hit) begin
               match <= 1'b1;
               if (auto_reload)
                  cnt <= 8'h00;
               else
                  en <= 1'b0;
            end else begin
               cnt <= cnt + 8'h01;
            end
         end
         if (wr) begin
            case (offset)
               OFF_CTRL: begin
                  en          <= DataOut_Bus[0];
                  auto_reload <= DataOut_Bus[1];
                  irq_en      <= DataOut_Bus[2];
               end
               OFF_PRESC: presc <= DataOut_Bus;
               OFF_CMP:   cmp   <= DataOut_Bus;
               OFF_CNT: begin
                  cnt  <= DataOut_Bus;
                  pcnt <= 8'h00;
               end
               OFF_PORT:  port  <= DataOut_Bus;
               default: ;
            endcase
         end
      end
   end

   always_comb begin
      DataIn_Bus = 8'h00;
      if (Sel_Hit && !RW) begin
         case (offset)
            OFF_CTRL:  DataIn_Bus = {5'b00000, irq_en, auto_reload, en};
            OFF_PRESC: DataIn_Bus = presc;
            OFF_CMP:   DataIn_Bus = cmp;
            OFF_CNT:   DataIn_Bus = cnt;
            OFF_STAT:  DataIn_Bus = {7'b0000000, match};
            OFF_PORT:  DataIn_Bus = port;
            default:   DataIn_Bus = 8'h00;
         endcase
      end
   end

endmodule

// File: doc/mmio_timer_port.md
Name: mmio_timer_port

Overview:
- Memory-mapped peripheral acting as responder on the processor data bus, in parallel with data RAM.
- The processor is the initiator; it supplies Address_Data_Bus, DataOut_Bus and RW, and receives read data on DataIn_Bus.
- The block decodes an 8-byte address window and provides an 8-bit timer/compare unit, an interrupt flag and an 8-bit output port.
- The top level muxes this block's read data against RAM using Sel_Hit.

Parameters:
- BASE_ADDR, 8'hF8: window base; block selected when Address_Data_Bus[7:3] == BASE_ADDR[7:3].

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous active-low reset; sampled on rising clk.
- Address_Data_Bus  input  8  data address from processor.
- DataOut_Bus  input  8  write data from processor.
- RW  input  1  1 = write, 0 = read.
- DataIn_Bus  output  8  read data to processor; 8'h00 when not selected.
- Sel_Hit  output  1  combinational; 1 when address is inside the window.
- Port_Out  output  8  PORT register value.
- Timer_Irq  output  1  MATCH & IRQ_EN, combinational from registers.

Behaviour:
- Register map (offset = Address_Data_Bus[2:0]):
  - 0 CTRL, RW: bit0 EN, bit1 AUTO_RELOAD, bit2 IRQ_EN; bits 7:3 read 0.
  - 1 PRESC, RW.
  - 2 CMP, RW.
  - 3 CNT, RW. A write loads CNT and clears the internal prescale counter.
  - 4 STAT: bit0 MATCH; write-1-to-clear; other bits read 0.
  - 5 PORT, RW.
  - 6, 7: read 8'h00; writes ignored.
- Reset (reset==0 at rising clk): CTRL, PRESC, CMP, CNT, STAT, PORT and the internal prescale counter all go to 0. Port_Out = 0 and Timer_Irq = 0 from the following cycle.
- Reads:
  - Combinational, zero wait states.
  - DataIn_Bus = selected register when Sel_Hit && RW==0, else 8'h00.
  - No read side effects.
- Writes: take effect at the rising clk where Sel_Hit && RW==1; the new value is visible on reads the next cycle.
- Prescaler (internal 8-bit pcnt), while EN=1:
  - If pcnt == PRESC: pcnt <= 0 and a tick is generated this cycle.
  - Else: pcnt <= pcnt + 1.
  - Tick period is PRESC+1 clocks; PRESC=0 gives a tick every clock.
  - While EN=0, pcnt holds.
- On tick:
  - If CNT == CMP: MATCH <= 1. If AUTO_RELOAD, CNT <= 0; else CNT holds and EN <= 0 (one-shot stop).
  - Else: CNT <= CNT + 1, modulo 256 (8'hFF wraps to 8'h00, no flag).
- Simultaneous events:
  - STAT W1C in the same cycle MATCH is set: set wins, MATCH = 1.
  - CNT write coinciding with a tick: the write wins and pcnt <= 0.
  - CTRL write coinciding with one-shot auto-clear of EN: the written CTRL value wins.
  - PRESC write: takes effect for the comparison from the next cycle; pcnt is not cleared.
- Reset mid-count: all state returns to 0 on that edge, and no tick or MATCH is produced in that cycle.
- Timer_Irq stays high until MATCH is cleared or IRQ_EN is cleared.

Test Plan:
1. Reset then read all 8 offsets at F8..FF -> all 8'h00. Read address 8'h10 -> Sel_Hit=0, DataIn_Bus=0.
2. Write PORT(FD)=8'hA5 -> Port_Out=8'hA5 the next cycle. Read FD returns 8'hA5. Write FE=8'h77 -> read FE=0, Port_Out unchanged.
3. PRESC=2, CMP=3, CTRL=8'h05 (EN, IRQ_EN, one-shot):
   - CNT increments every 3 clocks.
   - On the tick with CNT==3: MATCH=1, Timer_Irq=1, EN reads 0, CNT stays 3.
   - Write STAT=8'h01 -> Timer_Irq=0.
4. Auto-reload, PRESC=0, CMP=8'hFF, CTRL=8'h03:
   - CNT counts 0..FF, then MATCH sets and CNT returns to 0.
   - Separately, with CMP=2 and CNT preloaded 8'hFE: CNT wraps FE→FF→00→01→02, and MATCH sets only at 02.
5. Force a STAT W1C write on the exact MATCH-setting cycle -> MATCH reads 1. Force a CNT write (8'h40) on a tick cycle -> CNT reads 8'h40 and the next tick comes PRESC+1 clocks later.
6. Assert reset low for one clock mid-count with MATCH=1 and PORT=8'h3C -> all registers read 0, Timer_Irq=0, Port_Out=0, and no further counting.
